// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM for the multicycle MIPS datapath. Optional
//            ADDI support is enabled by defining MC_CTRL_ADDI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] C_IDLE   = 4'd0;
    localparam logic [3:0] C_FETCH  = 4'd1;
    localparam logic [3:0] C_DECODE = 4'd2;
    localparam logic [3:0] C_MEMADR = 4'd3;
    localparam logic [3:0] C_MEMRD  = 4'd4;
    localparam logic [3:0] C_MEMWB  = 4'd5;
    localparam logic [3:0] C_MEMWR  = 4'd6;
    localparam logic [3:0] C_EXEC   = 4'd7;
    localparam logic [3:0] C_ALUWB  = 4'd8;
    localparam logic [3:0] C_BRANCH = 4'd9;
    localparam logic [3:0] C_JUMP   = 4'd10;
`ifdef MC_CTRL_ADDI_EN
    localparam logic [3:0] C_ADDIEX = 4'd11;
    localparam logic [3:0] C_ADDIWB = 4'd12;
    localparam logic [5:0] C_OP_ADDI = 6'b001000;
`endif

    localparam logic [5:0] C_OP_R    = 6'b000000;
    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_J    = 6'b000010;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic [3:0] w_dispatch;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DECODE target for the current opcode; FETCH marks an unrecognised opcode.
    always_comb begin
        w_dispatch = C_FETCH;
        case (opcode)
            C_OP_LW, C_OP_SW: w_dispatch = C_MEMADR;
            C_OP_R:           w_dispatch = C_EXEC;
            C_OP_BEQ:         w_dispatch = C_BRANCH;
            C_OP_J:           w_dispatch = C_JUMP;
`ifdef MC_CTRL_ADDI_EN
            C_OP_ADDI:        w_dispatch = C_ADDIEX;
`endif
            default:          w_dispatch = C_FETCH;
        endcase
    end

    always_comb begin
        state_d = C_IDLE;
        case (state_q)
            C_IDLE:   state_d = C_FETCH;
            C_FETCH:  state_d = mem_ready ? C_DECODE : C_FETCH;
            C_DECODE: state_d = w_dispatch;
            C_MEMADR: state_d = (opcode == C_OP_LW) ? C_MEMRD : C_MEMWR;
            C_MEMRD:  state_d = mem_ready ? C_MEMWB : C_MEMRD;
            C_MEMWB:  state_d = C_FETCH;
            C_MEMWR:  state_d = mem_ready ? C_FETCH : C_MEMWR;
            C_EXEC:   state_d = C_ALUWB;
            C_ALUWB:  state_d = C_FETCH;
            C_BRANCH: state_d = C_FETCH;
            C_JUMP:   state_d = C_FETCH;
`ifdef MC_CTRL_ADDI_EN
            C_ADDIEX: state_d = C_ADDIWB;
            C_ADDIWB: state_d = C_FETCH;
`endif
            default:  state_d = C_IDLE;
        endcase
    end

    always_comb begin
        alu_op     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            C_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            C_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = (w_dispatch == C_FETCH);
            end
            C_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            C_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            C_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            C_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                retire    = mem_ready;
            end
            C_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            C_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            C_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            C_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire   = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            C_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            C_ADDIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Self-checking bench: directed vector table, reset-abort sequence
//            and a randomized instruction stream checked against a per-
//            instruction cycle model. Honours MC_CTRL_ADDI_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       retire;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       mr;
        outs_t      exp;
    } vec_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, retire, illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_ret    = 0;
    int n_ill    = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .pc_write   (pc_write),
        .branch     (branch),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .retire     (retire),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs of one cycle spent in state st.
    function automatic outs_t ex(input int st, input bit mr, input bit ill);
        outs_t o = '0;
        o.st = st[3:0];
        case (st)
            1:  begin o.mem_read = 1; o.src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
            2:  begin o.src_b = 2'b11; o.illegal_op = ill; end
            3:  begin o.src_a = 1; o.src_b = 2'b10; end
            4:  begin o.mem_read = 1; o.iord = 1; end
            5:  begin o.reg_write = 1; o.mem_to_reg = 1; o.retire = 1; end
            6:  begin o.mem_write = 1; o.iord = 1; o.retire = mr; end
            7:  begin o.src_a = 1; o.alu_op = 2'b10; end
            8:  begin o.reg_dst = 1; o.reg_write = 1; o.retire = 1; end
            9:  begin o.src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.branch = 1; o.retire = 1; end
            10: begin o.pc_src = 2'b10; o.pc_write = 1; o.retire = 1; end
            11: begin o.src_a = 1; o.src_b = 2'b10; end
            12: begin o.reg_write = 1; o.retire = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic vec_t mk(input logic r, input logic [5:0] op, input logic mr, input outs_t e);
        vec_t v;
        v.rst_n = r; v.op = op; v.mr = mr; v.exp = e;
        return v;
    endfunction

    function automatic bit legal(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic apply(input vec_t v, input string tag, input int idx);
        outs_t act;
        rst_n = v.rst_n; opcode = v.op; mem_ready = v.mr;
        @(negedge clk);
        act = {state, alu_op, alu_src_a, alu_src_b, pc_src, pc_write, branch, iord,
               mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, retire, illegal_op};
        n_checks++;
        if (act !== v.exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h (state %0d) expected %h (state %0d)",
                     tag, idx, act, act.st, v.exp, v.exp.st);
        end
        if (retire === 1'b1) n_ret++;
        if (illegal_op === 1'b1) n_ill++;
        @(posedge clk);
        #1;
    endtask

    // Expected cycle trace of one instruction: fetch waits, fetch, decode, then
    // the opcode's execution path with its memory waits.
    task automatic build(input logic [5:0] op, input int nf, input int nm, ref vec_t q[$]);
        bit ok = legal(op);
        for (int i = 0; i < nf; i++) q.push_back(mk(1, 6'($urandom), 0, ex(1, 0, 0)));
        q.push_back(mk(1, 6'($urandom), 1, ex(1, 1, 0)));
        q.push_back(mk(1, op, 1'($urandom), ex(2, 0, !ok)));
        if (ok) begin
            if (op == OP_LW || op == OP_SW) begin
                q.push_back(mk(1, op, 1'($urandom), ex(3, 0, 0)));
                for (int i = 0; i < nm; i++) q.push_back(mk(1, op, 0, ex(op == OP_LW ? 4 : 6, 0, 0)));
                if (op == OP_LW) begin
                    q.push_back(mk(1, op, 1, ex(4, 1, 0)));
                    q.push_back(mk(1, op, 1'($urandom), ex(5, 0, 0)));
                end else begin
                    q.push_back(mk(1, op, 1, ex(6, 1, 0)));
                end
            end else if (op == OP_R) begin
                q.push_back(mk(1, op, 1'($urandom), ex(7, 0, 0)));
                q.push_back(mk(1, op, 1'($urandom), ex(8, 0, 0)));
            end else if (op == OP_BEQ) begin
                q.push_back(mk(1, op, 1'($urandom), ex(9, 0, 0)));
            end else if (op == OP_J) begin
                q.push_back(mk(1, op, 1'($urandom), ex(10, 0, 0)));
            end else begin
                q.push_back(mk(1, op, 1'($urandom), ex(11, 0, 0)));
                q.push_back(mk(1, op, 1'($urandom), ex(12, 0, 0)));
            end
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t rq[$];
        logic [5:0] pool [9];
        int exp_ret, exp_ill;

        rst_n = 1'b0; opcode = '0; mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: reset release, LW, R with fetch stalls, BEQ, bad op, J, SW, ADDI.
        tbl.push_back(mk(0, OP_R,   0, ex(0, 0, 0)));
        tbl.push_back(mk(1, OP_R,   0, ex(0, 0, 0)));
        tbl.push_back(mk(1, OP_LW,  0, ex(1, 0, 0)));
        tbl.push_back(mk(1, OP_LW,  1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_LW,  1, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_LW,  1, ex(3, 0, 0)));
        tbl.push_back(mk(1, OP_LW,  1, ex(4, 1, 0)));
        tbl.push_back(mk(1, OP_LW,  1, ex(5, 0, 0)));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, OP_R, 0, ex(1, 0, 0)));
        tbl.push_back(mk(1, OP_R,   1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_R,   0, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_R,   0, ex(7, 0, 0)));
        tbl.push_back(mk(1, OP_R,   0, ex(8, 0, 0)));
        tbl.push_back(mk(1, OP_BEQ, 1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_BEQ, 1, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_BEQ, 1, ex(9, 0, 0)));
        tbl.push_back(mk(1, OP_BAD, 1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_BAD, 1, ex(2, 0, 1)));
        tbl.push_back(mk(1, OP_J,   1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_J,   1, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_J,   1, ex(10, 0, 0)));
        tbl.push_back(mk(1, OP_SW,  1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_SW,  1, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_SW,  0, ex(3, 0, 0)));
        tbl.push_back(mk(1, OP_SW,  0, ex(6, 0, 0)));
        tbl.push_back(mk(1, OP_SW,  1, ex(6, 1, 0)));
        tbl.push_back(mk(1, OP_ADDI, 1, ex(1, 1, 0)));
`ifdef MC_CTRL_ADDI_EN
        tbl.push_back(mk(1, OP_ADDI, 1, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_ADDI, 1, ex(11, 0, 0)));
        tbl.push_back(mk(1, OP_ADDI, 1, ex(12, 0, 0)));
`else
        tbl.push_back(mk(1, OP_ADDI, 1, ex(2, 0, 1)));
`endif
        // Reset abandons a stalled read.
        tbl.push_back(mk(1, OP_LW, 1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_LW, 1, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_LW, 0, ex(3, 0, 0)));
        tbl.push_back(mk(1, OP_LW, 0, ex(4, 0, 0)));
        tbl.push_back(mk(0, OP_LW, 0, ex(4, 0, 0)));
        tbl.push_back(mk(1, OP_LW, 0, ex(0, 0, 0)));
        tbl.push_back(mk(1, OP_SW, 0, ex(1, 0, 0)));
        // Reset abandons a stalled write.
        tbl.push_back(mk(1, OP_SW, 1, ex(1, 1, 0)));
        tbl.push_back(mk(1, OP_SW, 0, ex(2, 0, 0)));
        tbl.push_back(mk(1, OP_SW, 0, ex(3, 0, 0)));
        tbl.push_back(mk(0, OP_SW, 0, ex(6, 0, 0)));
        tbl.push_back(mk(1, OP_SW, 0, ex(0, 0, 0)));

        foreach (tbl[i]) apply(tbl[i], "vec", i);

        // Random instruction stream; DUT now sits in FETCH.
        pool = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BAD, 6'b001101, 6'b100000};
        exp_ret = 0; exp_ill = 0; n_ret = 0; n_ill = 0;
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op = pool[$urandom_range(0, 8)];
            build(op, $urandom_range(0, 3), $urandom_range(0, 3), rq);
            if (legal(op)) exp_ret++; else exp_ill++;
        end
        foreach (rq[i]) apply(rq[i], "rand", i);

        n_checks++;
        if (n_ret != exp_ret) begin
            n_fail++;
            $display("FAIL retire_count: got %0d expected %0d", n_ret, exp_ret);
        end
        n_checks++;
        if (n_ill != exp_ill) begin
            n_fail++;
            $display("FAIL illegal_count: got %0d expected %0d", n_ill, exp_ill);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath strobe and mux select, including the 2-bit `alu_op` consumed by the ALU control decoder.
- Waits on a memory-ready handshake in the fetch and memory-access states.
- Raises a one-cycle `retire` pulse per completed instruction.

## Interface
Parameters:
- none (opcode map fixed: R 6'b000000, LW 6'b100011, SW 6'b101011, BEQ 6'b000100, J 6'b000010, ADDI 6'b001000)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset: synchronous and active-low
- opcode  in  6  instr[31:26] from the instruction register; stable from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  2  00 add, 01 subtract (BEQ), 10 use funct
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write  out  1 each  datapath strobes/selects
- retire  out  1  one-cycle pulse when an instruction completes
- illegal_op  out  1  one-cycle pulse in DECODE for an unrecognised opcode
- state  out  4  current state encoding (debug/verification)

## Operation
State encoding:
- 0 IDLE, 1 FETCH, 2 DECODE, 3 MEMADR, 4 MEMRD, 5 MEMWB, 6 MEMWR
- 7 EXEC, 8 ALUWB, 9 BRANCH, 10 JUMP, 11 ADDIEX, 12 ADDIWB
- 13–15 unused; any of them returns to IDLE next cycle

Outputs are Moore decodes of state, except those gated by `mem_ready`. Anything not listed below is 0.
- IDLE: all 0. Next state FETCH.
- FETCH: mem_read=1, alu_src_b=01. ir_write=pc_write=mem_ready. Hold while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_b=11. Dispatch on opcode:
  - LW/SW → MEMADR
  - R → EXEC
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDIEX
  - anything else → FETCH with illegal_op=1
- MEMADR: alu_src_a=1, alu_src_b=10. LW → MEMRD; SW → MEMWR.
- MEMRD: mem_read=1, iord=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, retire=1. Next FETCH.
- MEMWR: mem_write=1, iord=1. Hold until mem_ready=1, then FETCH; retire=mem_ready.
- EXEC: alu_src_a=1, alu_op=10. Next ALUWB.
- ALUWB: reg_dst=1, reg_write=1, retire=1. Next FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_src=01, branch=1, retire=1. Next FETCH.
- JUMP: pc_src=10, pc_write=1, retire=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10. Next ADDIWB.
- ADDIWB: reg_write=1, retire=1. Next FETCH.

## Timing
- Reset:
  - rst_n=0 sampled at any edge, in any state, forces state=IDLE on that edge.
  - All outputs are 0 while in IDLE.
  - The first FETCH occurs the cycle after rst_n is sampled high.
- Cycles per instruction with mem_ready=1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3. Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- pc_write and ir_write assert for exactly one cycle per fetch: the cycle mem_ready=1 in FETCH.
- Reset during MEMRD or MEMWR abandons the access. mem_read/mem_write are 0 the cycle after the reset edge.
- illegal_op and retire never assert in the same cycle. retire asserts at most once per instruction.

## Configuration
- MC_CTRL_ADDI_EN defined: ADDI opcode dispatches to ADDIEX → ADDIWB.
- MC_CTRL_ADDI_EN undefined:
  - states 11 and 12 are not reachable and not decoded;
  - ADDI is an illegal opcode (illegal_op=1, return to FETCH);
  - states 11/12, if forced, go to IDLE.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 → state=0 with all outputs 0 for one cycle, then state=1 with mem_read=1 and alu_src_b=01.
- LW, mem_ready=1 throughout, opcode=6'b100011 → state sequence 1,2,3,4,5,1. In state 5: reg_write=1, mem_to_reg=1, retire=1 once.
- R-type with mem_ready=0 for 3 cycles in FETCH:
  - ir_write and pc_write stay 0 for 3 cycles, then pulse for 1 cycle;
  - EXEC then drives alu_op=10;
  - ALUWB drives reg_dst=1, reg_write=1.
- BEQ, opcode=6'b000100 → states 1,2,9,1. In state 9: alu_op=01, branch=1, pc_src=01, retire=1.
- opcode=6'b111111 → illegal_op=1 in DECODE only, next state FETCH; reg_write and mem_write never assert.
- Two further checks:
  - ADDI with MC_CTRL_ADDI_EN: states 1,2,11,12,1. Without the macro: illegal_op=1.
  - rst_n=0 while in MEMRD with mem_ready=0 → state=0, mem_read=0 next cycle.
